haz_scoreboard: RTL and testbench
=================================

// Module: haz_scoreboard
// PURPOSE
//  Parametrised scoreboard hazard unit for the in-order pipeline; it sits beside decode (stage 0).
//  - Keeps a per-register countdown of cycles until an in-flight result can be forwarded.
//  - Stalls decode when a source operand is not yet forwardable, with different slack for
//    compare (resolved in decode) and normal ops (forwarded into EX).
//  - Generalises load-use and ALU->cmp interlocks to arbitrary latencies; adds flush handling
//    and a saturating stall-cycle counter.
// PARAMETERS
//  REG_SELECT  5   register index width; 2**REG_SELECT registers tracked
//  ALU_LAT     1   countdown loaded for ALU writers (1..LOAD_LAT)
//  LOAD_LAT    2   countdown loaded for load writers (>=ALU_LAT)
//  CNT_W       16  width of stall-cycle performance counter
//  ZERO_REG    1   1: register 0 is hardwired zero, never tracked, never stalls
// PORTS
//  i_clk            in   1           clock, rising edge
//  i_rst_n          in   1           async active-low reset
//  i_valid_0        in   1           decode holds a valid instruction
//  i_flush          in   1           kill decode instruction this cycle
//  i_uses_a_0       in   1           instruction reads reg a
//  i_uses_b_0       in   1           instruction reads reg b
//  i_is_cmp_0       in   1           instruction needs operands in decode (compare/branch)
//  i_is_write_0     in   1           instruction writes reg c
//  i_is_load_0      in   1           writer is a load (selects LOAD_LAT)
//  i_reg_a_select_0 in   REG_SELECT  source a index
//  i_reg_b_select_0 in   REG_SELECT  source b index
//  i_reg_c_select_0 in   REG_SELECT  destination index
//  o_nop            out  1           stall decode / inject bubble this cycle
//  o_busy           out  1           any counter nonzero
//  o_stall_cycles   out  CNT_W       saturating count of cycles with o_nop=1
// BEHAVIOUR
//  - State: cnt[r], width $clog2(LOAD_LAT+1), one per register. Reset: all cnt=0,
//    o_stall_cycles=0; o_nop=0 and o_busy=0 follow combinationally.
//  - Slack: SLACK=0 if i_is_cmp_0, else 1. Source r blocks when used and cnt[r] > SLACK.
//  - o_nop = i_valid_0 & ~i_flush & (block_a | block_b). Combinational, same cycle.
//  - Issue = i_valid_0 & ~i_flush & ~o_nop.
//  - Every edge: each nonzero cnt decrements by 1 (floor 0).
//  - On issue with i_is_write_0 (and c!=0 when ZERO_REG):
//    cnt[c] <= i_is_load_0 ? LOAD_LAT : ALU_LAT.
//    This overrides the decrement of the same entry (WAW: newest latency wins).
//  - Stalled or flushed instructions never update cnt.
//    Decrement continues during stall, so a stall lasts exactly cnt[r]-SLACK cycles.
//  - Default timing: load->use 1 bubble; load->cmp 2; ALU->cmp 1; ALU->normal 0.
//  - Source and destination equal in one instruction: block uses the pre-update cnt.
//  - ZERO_REG=1: r0 reads never block; r0 writes ignored.
//  - i_flush: forces o_nop=0 and suppresses issue; in-flight counts keep decrementing.
//  - o_stall_cycles: +1 per edge with o_nop=1; holds at 2**CNT_W-1.
//  - Async reset mid-stall: all state cleared immediately; o_nop drops the same instant.
// TESTING
//  - Load r5, then add r6<-r5: 1 cycle o_nop=1, issue next; o_stall_cycles=1.
//  - ALU write r7, then cmp r7,r8: o_nop=1 one cycle. Same with add r9<-r7: no stall.
//  - Load r3, then cmp r3,r4: o_nop=1 for 2 cycles. Then o_busy=0 one cycle after issue.
//  - ALU write r0, then cmp r0,r0 (ZERO_REG=1): no stall, o_busy stays 0.
//  - Load r5, then flush+use r5 next cycle: o_nop=0, no cnt update; use r5 after: 0 stall.
//  - CNT_W=4, held blocked by repeated load r1 then use r1 for 20 stall cycles:
//    counter saturates at 15. Assert i_rst_n=0 mid-stall: o_nop=0, counter=0 at once.

Source files
------------

// File: rtl/haz_scoreboard.sv
// ---------------------------------------------------------------------------
// haz_scoreboard
//   Hazard unit that sits beside decode. Each architectural register has a
//   small countdown giving the number of cycles until its in-flight result
//   can be forwarded. Decode is stalled while a source operand is not yet
//   forwardable. Compare/branch ops resolve in decode and need the value one
//   cycle earlier than normal ops, which are forwarded into EX.
//
// Ports
//   i_clk, i_rst_n       clock (rising edge), async active-low reset
//   i_valid_0            decode holds a valid instruction
//   i_flush              kill the decode instruction this cycle
//   i_uses_a_0/_b_0      instruction reads source a / b
//   i_is_cmp_0           operands needed in decode (compare/branch)
//   i_is_write_0         instruction writes destination c
//   i_is_load_0          writer is a load (longer latency)
//   i_reg_*_select_0     source a, source b, destination c indices
//   o_nop                stall decode / inject bubble this cycle
//   o_busy               some register still has a result in flight
//   o_stall_cycles       saturating count of cycles with o_nop high
// ---------------------------------------------------------------------------
module haz_scoreboard #(
   parameter int REG_SELECT = 5,
   parameter int ALU_LAT    = 1,
   parameter int LOAD_LAT   = 2,
   parameter int CNT_W      = 16,
   parameter int ZERO_REG   = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid_0,
   input  logic                  i_flush,
   input  logic                  i_uses_a_0,
   input  logic                  i_uses_b_0,
   input  logic                  i_is_cmp_0,
   input  logic                  i_is_write_0,
   input  logic                  i_is_load_0,
   input  logic [REG_SELECT-1:0] i_reg_a_select_0,
   input  logic [REG_SELECT-1:0] i_reg_b_select_0,
   input  logic [REG_SELECT-1:0] i_reg_c_select_0,
   output logic                  o_nop,
   output logic                  o_busy,
   output logic [CNT_W-1:0]      o_stall_cycles
);

   localparam int NREG = 2 ** REG_SELECT;
   localparam int CW   = $clog2(LOAD_LAT + 1);

   typedef logic [CW-1:0] cnt_t;

   cnt_t             r_cnt [NREG];
   logic [CNT_W-1:0] r_stallCycles;

   cnt_t w_slack;
   cnt_t w_cntA;
   cnt_t w_cntB;
   cnt_t w_loadVal;
   logic w_zeroA;
   logic w_zeroB;
   logic w_zeroC;
   logic w_blockA;
   logic w_blockB;
   logic w_nop;
   logic w_issue;
   logic w_write;
   logic w_busy;

   // A compare needs the value in decode itself, so it tolerates no
   // remaining latency; a normal op can still catch the forward into EX.
   assign w_slack   = i_is_cmp_0 ? '0 : cnt_t'(1);
   assign w_cntA    = r_cnt[i_reg_a_select_0];
   assign w_cntB    = r_cnt[i_reg_b_select_0];
   assign w_zeroA   = (ZERO_REG != 0) && (i_reg_a_select_0 == '0);
   assign w_zeroB   = (ZERO_REG != 0) && (i_reg_b_select_0 == '0);
   assign w_zeroC   = (ZERO_REG != 0) && (i_reg_c_select_0 == '0);
   assign w_blockA  = i_uses_a_0 && !w_zeroA && (w_cntA > w_slack);
   assign w_blockB  = i_uses_b_0 && !w_zeroB && (w_cntB > w_slack);

   // Blocking uses the current (pre-update) counts, so an instruction whose
   // source equals its destination waits on the older writer.
   assign w_nop     = i_valid_0 && !i_flush && (w_blockA || w_blockB);
   assign w_issue   = i_valid_0 && !i_flush && !w_nop;
   assign w_write   = w_issue && i_is_write_0 && !w_zeroC;
   assign w_loadVal = i_is_load_0 ? cnt_t'(LOAD_LAT) : cnt_t'(ALU_LAT);

   // Busy whenever any register still has a result in flight.
   always_comb begin
      w_busy = 1'b0;
      for (int r = 0; r < NREG; r++) begin
         if (r_cnt[r] != '0) begin
            w_busy = 1'b1;
         end
      end
   end

   // Counters tick down every cycle, including during stalls and flushes.
   // A newly issued writer reloads its destination, overriding the tick so
   // the newest latency wins on a write-after-write.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            r_cnt[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if (w_write && (i_reg_c_select_0 == REG_SELECT'(r))) begin
               r_cnt[r] <= w_loadVal;
            end else if (r_cnt[r] != '0) begin
               r_cnt[r] <= r_cnt[r] - cnt_t'(1);
            end
         end
      end
   end

   // Stall-cycle counter sticks at all-ones rather than wrapping.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stallCycles <= '0;
      end else if (w_nop && !(&r_stallCycles)) begin
         r_stallCycles <= r_stallCycles + CNT_W'(1);
      end
   end

   assign o_nop          = w_nop;
   assign o_busy         = w_busy;
   assign o_stall_cycles = r_stallCycles;

endmodule

// File: tb/tb_haz_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_haz_scoreboard
//   Drives decode-stage instruction sequences into haz_scoreboard (built with
//   a 4-bit stall counter) and compares o_nop, o_busy and o_stall_cycles
//   against expected values queued alongside each stimulus cycle.
// ---------------------------------------------------------------------------
module tb_haz_scoreboard;

   logic       i_clk;
   logic       i_rst_n;
   logic       i_valid_0;
   logic       i_flush;
   logic       i_uses_a_0;
   logic       i_uses_b_0;
   logic       i_is_cmp_0;
   logic       i_is_write_0;
   logic       i_is_load_0;
   logic [4:0] i_reg_a_select_0;
   logic [4:0] i_reg_b_select_0;
   logic [4:0] i_reg_c_select_0;
   logic       o_nop;
   logic       o_busy;
   logic [3:0] o_stall_cycles;

   int nCompared;
   int nMismatched;

   typedef struct {
      logic       valid, flush, ua, ub, cmp, wr, ld;
      logic [4:0] a, b, c;
      logic       nop, busy;
      logic [3:0] stall;
   } step_t;

   typedef struct {
      logic       nop, busy;
      logic [3:0] stall;
   } exp_t;

   exp_t expQ[$];

   haz_scoreboard #(
      .REG_SELECT(5), .ALU_LAT(1), .LOAD_LAT(2), .CNT_W(4), .ZERO_REG(1)
   ) dut (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .i_valid_0        (i_valid_0),
      .i_flush          (i_flush),
      .i_uses_a_0       (i_uses_a_0),
      .i_uses_b_0       (i_uses_b_0),
      .i_is_cmp_0       (i_is_cmp_0),
      .i_is_write_0     (i_is_write_0),
      .i_is_load_0      (i_is_load_0),
      .i_reg_a_select_0 (i_reg_a_select_0),
      .i_reg_b_select_0 (i_reg_b_select_0),
      .i_reg_c_select_0 (i_reg_c_select_0),
      .o_nop            (o_nop),
      .o_busy           (o_busy),
      .o_stall_cycles   (o_stall_cycles)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Hard time limit so a wedged run still ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Stimulus constructors for the instruction kinds used below.
   function automatic step_t st(input logic v, f, ua, ub, cm, wr, ld,
                                input logic [4:0] a, b, c,
                                input logic n, bz, input logic [3:0] s);
      step_t x;
      x.valid = v; x.flush = f; x.ua = ua; x.ub = ub; x.cmp = cm;
      x.wr = wr; x.ld = ld; x.a = a; x.b = b; x.c = c;
      x.nop = n; x.busy = bz; x.stall = s;
      return x;
   endfunction

   function automatic step_t idle(input logic n, bz, input logic [3:0] s);
      return st(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, n, bz, s);
   endfunction

   function automatic step_t loadTo(input logic [4:0] c, input logic n, bz, input logic [3:0] s);
      return st(1, 0, 0, 0, 0, 1, 1, 5'd0, 5'd0, c, n, bz, s);
   endfunction

   function automatic step_t aluTo(input logic [4:0] c, input logic n, bz, input logic [3:0] s);
      return st(1, 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, c, n, bz, s);
   endfunction

   function automatic step_t addUse(input logic [4:0] a, c, input logic n, bz, input logic [3:0] s);
      return st(1, 0, 1, 0, 0, 1, 0, a, 5'd0, c, n, bz, s);
   endfunction

   function automatic step_t cmpUse(input logic [4:0] a, b, input logic n, bz, input logic [3:0] s);
      return st(1, 0, 1, 1, 1, 0, 0, a, b, 5'd0, n, bz, s);
   endfunction

   // Drives one decode cycle just after the falling edge and queues the
   // outputs that cycle must show.
   task automatic applyStimulus(input step_t s);
      exp_t e;
      @(negedge i_clk);
      i_valid_0        = s.valid;
      i_flush          = s.flush;
      i_uses_a_0       = s.ua;
      i_uses_b_0       = s.ub;
      i_is_cmp_0       = s.cmp;
      i_is_write_0     = s.wr;
      i_is_load_0      = s.ld;
      i_reg_a_select_0 = s.a;
      i_reg_b_select_0 = s.b;
      i_reg_c_select_0 = s.c;
      e.nop = s.nop; e.busy = s.busy; e.stall = s.stall;
      expQ.push_back(e);
   endtask

   task automatic doReset();
      @(negedge i_clk);
      i_rst_n = 1'b0;
      i_valid_0 = 1'b0; i_flush = 1'b0; i_uses_a_0 = 1'b0; i_uses_b_0 = 1'b0;
      i_is_cmp_0 = 1'b0; i_is_write_0 = 1'b0; i_is_load_0 = 1'b0;
      i_reg_a_select_0 = '0; i_reg_b_select_0 = '0; i_reg_c_select_0 = '0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      exp_t e;
      doReset();
      i_rst_n = 1'b0;
      applyStimulus(cmpUse(5'd1, 5'd2, 0, 0, 4'd0));
      #1;
      e = expQ.pop_front();
      nCompared += 3;
      if (o_nop !== e.nop) begin
         nMismatched++;
         $display("[TB] FAIL reset nop: got %b required %b", o_nop, e.nop);
      end
      if (o_busy !== e.busy) begin
         nMismatched++;
         $display("[TB] FAIL reset busy: got %b required %b", o_busy, e.busy);
      end
      if (o_stall_cycles !== e.stall) begin
         nMismatched++;
         $display("[TB] FAIL reset stall: got %0d required %0d", o_stall_cycles, e.stall);
      end
      i_rst_n = 1'b1;
   endtask

   task automatic test_load_use();
      step_t s[$];
      exp_t  e;
      doReset();
      s.push_back(loadTo(5'd5, 0, 0, 4'd0));
      s.push_back(addUse(5'd5, 5'd6, 1, 1, 4'd0));
      s.push_back(addUse(5'd5, 5'd6, 0, 1, 4'd1));
      s.push_back(idle(0, 1, 4'd1));
      s.push_back(idle(0, 0, 4'd1));
      foreach (s[i]) begin
         applyStimulus(s[i]);
         #1;
         e = expQ.pop_front();
         nCompared += 3;
         if (o_nop !== e.nop) begin
            nMismatched++;
            $display("[TB] FAIL load_use step%0d nop: got %b required %b", i, o_nop, e.nop);
         end
         if (o_busy !== e.busy) begin
            nMismatched++;
            $display("[TB] FAIL load_use step%0d busy: got %b required %b", i, o_busy, e.busy);
         end
         if (o_stall_cycles !== e.stall) begin
            nMismatched++;
            $display("[TB] FAIL load_use step%0d stall: got %0d required %0d", i, o_stall_cycles, e.stall);
         end
      end
   endtask

   task automatic test_alu_cmp();
      step_t s[$];
      exp_t  e;
      doReset();
      s.push_back(aluTo(5'd7, 0, 0, 4'd0));
      s.push_back(cmpUse(5'd7, 5'd8, 1, 1, 4'd0));
      s.push_back(cmpUse(5'd7, 5'd8, 0, 0, 4'd1));
      s.push_back(aluTo(5'd7, 0, 0, 4'd1));
      s.push_back(addUse(5'd7, 5'd9, 0, 1, 4'd1));
      s.push_back(idle(0, 1, 4'd1));
      s.push_back(idle(0, 0, 4'd1));
      foreach (s[i]) begin
         applyStimulus(s[i]);
         #1;
         e = expQ.pop_front();
         nCompared += 3;
         if (o_nop !== e.nop) begin
            nMismatched++;
            $display("[TB] FAIL alu_cmp step%0d nop: got %b required %b", i, o_nop, e.nop);
         end
         if (o_busy !== e.busy) begin
            nMismatched++;
            $display("[TB] FAIL alu_cmp step%0d busy: got %b required %b", i, o_busy, e.busy);
         end
         if (o_stall_cycles !== e.stall) begin
            nMismatched++;
            $display("[TB] FAIL alu_cmp step%0d stall: got %0d required %0d", i, o_stall_cycles, e.stall);
         end
      end
   endtask

   task automatic test_load_cmp();
      step_t s[$];
      exp_t  e;
      doReset();
      s.push_back(loadTo(5'd3, 0, 0, 4'd0));
      s.push_back(cmpUse(5'd3, 5'd4, 1, 1, 4'd0));
      s.push_back(cmpUse(5'd3, 5'd4, 1, 1, 4'd1));
      s.push_back(cmpUse(5'd3, 5'd4, 0, 0, 4'd2));
      s.push_back(idle(0, 0, 4'd2));
      foreach (s[i]) begin
         applyStimulus(s[i]);
         #1;
         e = expQ.pop_front();
         nCompared += 3;
         if (o_nop !== e.nop) begin
            nMismatched++;
            $display("[TB] FAIL load_cmp step%0d nop: got %b required %b", i, o_nop, e.nop);
         end
         if (o_busy !== e.busy) begin
            nMismatched++;
            $display("[TB] FAIL load_cmp step%0d busy: got %b required %b", i, o_busy, e.busy);
         end
         if (o_stall_cycles !== e.stall) begin
            nMismatched++;
            $display("[TB] FAIL load_cmp step%0d stall: got %0d required %0d", i, o_stall_cycles, e.stall);
         end
      end
   endtask

   task automatic test_zero_reg();
      step_t s[$];
      exp_t  e;
      doReset();
      s.push_back(aluTo(5'd0, 0, 0, 4'd0));
      s.push_back(cmpUse(5'd0, 5'd0, 0, 0, 4'd0));
      s.push_back(loadTo(5'd0, 0, 0, 4'd0));
      s.push_back(idle(0, 0, 4'd0));
      foreach (s[i]) begin
         applyStimulus(s[i]);
         #1;
         e = expQ.pop_front();
         nCompared += 2;
         if (o_nop !== e.nop) begin
            nMismatched++;
            $display("[TB] FAIL zero_reg step%0d nop: got %b required %b", i, o_nop, e.nop);
         end
         if (o_busy !== e.busy) begin
            nMismatched++;
            $display("[TB] FAIL zero_reg step%0d busy: got %b required %b", i, o_busy, e.busy);
         end
      end
   endtask

   task automatic test_flush();
      step_t s[$];
      exp_t  e;
      doReset();
      s.push_back(loadTo(5'd5, 0, 0, 4'd0));
      // Flushed load-use of r5 that also reloads r5: must neither stall nor write.
      s.push_back(st(1, 1, 1, 0, 0, 1, 1, 5'd5, 5'd0, 5'd5, 0, 1, 4'd0));
      s.push_back(addUse(5'd5, 5'd6, 0, 1, 4'd0));
      s.push_back(idle(0, 1, 4'd0));
      s.push_back(idle(0, 0, 4'd0));
      foreach (s[i]) begin
         applyStimulus(s[i]);
         #1;
         e = expQ.pop_front();
         nCompared += 3;
         if (o_nop !== e.nop) begin
            nMismatched++;
            $display("[TB] FAIL flush step%0d nop: got %b required %b", i, o_nop, e.nop);
         end
         if (o_busy !== e.busy) begin
            nMismatched++;
            $display("[TB] FAIL flush step%0d busy: got %b required %b", i, o_busy, e.busy);
         end
         if (o_stall_cycles !== e.stall) begin
            nMismatched++;
            $display("[TB] FAIL flush step%0d stall: got %0d required %0d", i, o_stall_cycles, e.stall);
         end
      end
   endtask

   // Keeps decode mostly blocked with a compare that reads and reloads r1,
   // tracking the expected countdown and saturating stall count, then pulls
   // reset while a stall is active.
   task automatic test_saturation();
      exp_t e;
      int   cnt;
      int   stalls;
      step_t s;
      doReset();
      applyStimulus(loadTo(5'd1, 0, 0, 4'd0));
      #1;
      void'(expQ.pop_front());
      cnt    = 2;
      stalls = 0;
      for (int i = 0; i < 30; i++) begin
         s = st(1, 0, 1, 0, 1, 1, 1, 5'd1, 5'd0, 5'd1,
                (cnt > 0), (cnt != 0), 4'(stalls));
         applyStimulus(s);
         #1;
         e = expQ.pop_front();
         nCompared += 2;
         if (o_nop !== e.nop) begin
            nMismatched++;
            $display("[TB] FAIL saturation step%0d nop: got %b required %b", i, o_nop, e.nop);
         end
         if (o_stall_cycles !== e.stall) begin
            nMismatched++;
            $display("[TB] FAIL saturation step%0d stall: got %0d required %0d", i, o_stall_cycles, e.stall);
         end
         if (cnt > 0) begin
            cnt--;
            if (stalls < 15) stalls++;
         end else begin
            cnt = 2;
         end
      end
      applyStimulus(st(1, 0, 1, 0, 1, 1, 1, 5'd1, 5'd0, 5'd1, 1, 1, 4'd15));
      #1;
      e = expQ.pop_front();
      nCompared += 2;
      if (o_nop !== e.nop) begin
         nMismatched++;
         $display("[TB] FAIL sat_prereset nop: got %b required %b", o_nop, e.nop);
      end
      if (o_stall_cycles !== e.stall) begin
         nMismatched++;
         $display("[TB] FAIL sat_prereset stall: got %0d required %0d", o_stall_cycles, e.stall);
      end
      i_rst_n = 1'b0;
      #1;
      nCompared += 3;
      if (o_nop !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL async_reset nop: got %b required 0", o_nop);
      end
      if (o_busy !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL async_reset busy: got %b required 0", o_busy);
      end
      if (o_stall_cycles !== 4'd0) begin
         nMismatched++;
         $display("[TB] FAIL async_reset stall: got %0d required 0", o_stall_cycles);
      end
      @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      i_rst_n     = 1'b0;
      test_reset();
      test_load_use();
      test_alu_cmp();
      test_load_cmp();
      test_zero_reg();
      test_flush();
      test_saturation();
      if (expQ.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL scoreboard_drain: got %0d leftover entries required 0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
